dmem_wait_ctrl: RTL and testbench

- Parametrised data memory for the MEM stage of the ARM-subset pipeline.
- Successor to the fixed 64-word, zero-latency data memory.
- Adds configurable depth and base address, programmable wait states with a ready handshake that drives the pipeline freeze, registered read data, and an address-error flag.
- Optional byte-lane write masking.

---
 rtl/dmem_wait_ctrl.sv | 110 +++++++++++
 tb/tb_dmem_wait_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: MEM-stage data memory with programmable wait states, ready handshake and address-error flag.
//   Optional build macro DMEM_BYTE_LANE_EN: writes honour the latched byte_en lane mask.
//   Parameters: DEPTH (words, power of 2), BASE_ADDR (byte address of word 0), WAIT_CYCLES (0..15 stalls).
//   Ports: clk, rst (async active-low), addr/wdata/mem_w_en/mem_r_en/byte_en request inputs,
//          rdata (registered read data), ready (0 freezes pipeline), addr_err (last access out of range/misaligned).
module dmem_wait_ctrl #(
   parameter int          DEPTH       = 64,
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          WAIT_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_w_en,
   input  logic        mem_r_en,
   input  logic [3:0]  byte_en,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        addr_err
);
   localparam int         AW = $clog2(DEPTH);
   localparam logic [3:0] WC = 4'(WAIT_CYCLES);
   localparam bit         ZW = (WAIT_CYCLES == 0);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   state_t        state, nxt;
   logic [3:0]    cnt;
   logic [31:0]   mem [DEPTH];
   logic [31:0]   l_addr, l_wdata;
   logic          l_wr;
   logic [3:0]    l_be;
   logic          req, idle, c_wr, err, acc;
   logic [31:0]   c_addr, c_wdata, off, wword;
   logic [3:0]    c_be;
   logic [AW-1:0] idx;
   assign req  = mem_r_en | mem_w_en;
   assign idle = state == S_IDLE;
   // In IDLE the access (zero-wait case) uses live inputs; afterwards only the latched copy matters.
   assign c_addr  = idle ? addr : l_addr;
   assign c_wdata = idle ? wdata : l_wdata;
   assign c_wr    = idle ? mem_w_en : l_wr;
   assign c_be    = idle ? byte_en : l_be;
   assign off = c_addr - BASE_ADDR;
   assign idx = off[AW+1:2];
   // BASE_ADDR is word aligned, so off[1:0] equals the address alignment bits.
   assign err = (c_addr < BASE_ADDR) | (|off[31:AW+2]) | (|off[1:0]);
`ifdef DMEM_BYTE_LANE_EN
   always_comb begin
      wword = mem[idx];
      for (int i = 0; i < 4; i++) wword[8*i+:8] = c_be[i] ? c_wdata[8*i+:8] : mem[idx][8*i+:8];
   end
`else
   logic unused_be;
   assign unused_be = ^c_be;
   assign wword     = c_wdata;
`endif
   always_comb begin
      nxt   = state;
      ready = 1'b0;
      acc   = 1'b0;
      case (state)
         S_IDLE: begin
            ready = ~req;
            nxt   = req ? (ZW ? S_DONE : S_WAIT) : S_IDLE;
            acc   = req & ZW;
         end
         S_WAIT: begin
            nxt = (cnt == 4'd1) ? S_DONE : S_WAIT;
            acc = cnt == 4'd1;
         end
         S_DONE: begin
            ready = 1'b1;
            nxt   = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         rdata    <= '0;
         addr_err <= 1'b0;
         l_addr   <= '0;
         l_wdata  <= '0;
         l_wr     <= 1'b0;
         l_be     <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state <= nxt;
         if (idle && req) begin
            l_addr  <= addr;
            l_wdata <= wdata;
            l_wr    <= mem_w_en;
            l_be    <= byte_en;
            cnt     <= WC;
         end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (acc) begin
            addr_err <= err;
            if (c_wr) begin
               if (!err) mem[idx] <= wword;
            end else begin
               rdata <= err ? '0 : mem[idx];
            end
         end
      end
   end
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb_dmem_wait_ctrl: directed scoreboard bench driving a 3-wait and a 0-wait instance with the same accesses.
module tb_dmem_wait_ctrl;
   logic        clk = 1'b0, rst = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic        mem_w_en = 1'b0, mem_r_en = 1'b0;
   logic [3:0]  byte_en = '0;
   logic [31:0] rdata3, rdata0;
   logic        ready3, ready0, err3, err0;
   int          ntests = 0, nfail = 0;
   typedef struct packed {logic [31:0] rd; logic er;} exp_t;
   exp_t        sb[$];
   logic [31:0] mdl [64];
   logic [31:0] m_rd;
   always #5 clk = ~clk;
   dmem_wait_ctrl #(.DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(3)) u3 (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
      .byte_en(byte_en), .rdata(rdata3), .ready(ready3), .addr_err(err3));
   dmem_wait_ctrl #(.DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
      .byte_en(byte_en), .rdata(rdata0), .ready(ready0), .addr_err(err0));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic acc(input string tag, input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
      exp_t       e;
      logic       er;
      logic [5:0] ix;
      int         lo3, lo0;
      bit         d3, d0;
      er = (a < 32'd1024) || (a >= 32'd1280) || (a[1:0] != 2'b00);
      ix = a[7:2];
      if (w) begin
         if (!er) begin
`ifdef DMEM_BYTE_LANE_EN
            for (int i = 0; i < 4; i++) if (be[i]) mdl[ix][8*i+:8] = d[8*i+:8];
`else
            mdl[ix] = d;
`endif
         end
      end else begin
         m_rd = er ? 32'd0 : mdl[ix];
      end
      sb.push_back('{m_rd, er});
      @(negedge clk);
      addr = a; wdata = d; mem_w_en = w; mem_r_en = r; byte_en = be;
      lo3 = 0; lo0 = 0; d3 = 0; d0 = 0;
      for (int k = 0; k < 40 && !(d3 && d0); k++) begin
         #1;
         if (!d0) begin
            if (ready0) begin
               d0 = 1;
               chk({tag, "/w0_lat"}, lo0, 1);
               chk({tag, "/w0_rdata"}, rdata0, sb[0].rd);
               chk({tag, "/w0_err"}, {31'd0, err0}, {31'd0, sb[0].er});
            end else lo0++;
         end
         if (!d3) begin
            if (ready3) begin
               d3 = 1;
               e = sb.pop_front();
               chk({tag, "/w3_lat"}, lo3, 4);
               chk({tag, "/w3_rdata"}, rdata3, e.rd);
               chk({tag, "/w3_err"}, {31'd0, err3}, {31'd0, e.er});
            end else lo3++;
         end
         @(negedge clk);
         if (k == 0) begin
            mem_w_en = 0; mem_r_en = 0; addr = ~a; wdata = ~d; byte_en = ~be;
         end
      end
      if (!(d3 && d0)) chk({tag, "/timeout"}, {30'd0, d3, d0}, 32'd3);
   endtask
   initial begin
      for (int i = 0; i < 64; i++) mdl[i] = '0;
      m_rd = '0;
      #12 rst = 1'b1;
      @(negedge clk); #1;
      chk("rst/ready3", {31'd0, ready3}, 32'd1);
      chk("rst/rdata3", rdata3, 32'd0);
      chk("rst/err3", {31'd0, err3}, 32'd0);
      chk("rst/ready0", {31'd0, ready0}, 32'd1);
      chk("rst/rdata0", rdata0, 32'd0);
      chk("rst/err0", {31'd0, err0}, 32'd0);
      acc("rd1024", 0, 1, 32'd1024, 32'h0, 4'hF);
      acc("wr1028", 1, 0, 32'd1028, 32'hDEADBEEF, 4'hF);
      acc("rd1028", 0, 1, 32'd1028, 32'h0, 4'hF);
      acc("rd1024b", 0, 1, 32'd1024, 32'h0, 4'hF);
      acc("wr1024", 1, 0, 32'd1024, 32'hCAFEF00D, 4'hF);
      acc("rd1280", 0, 1, 32'd1280, 32'h0, 4'hF);
      acc("rd1024c", 0, 1, 32'd1024, 32'h0, 4'hF);
      acc("rd1020", 0, 1, 32'd1020, 32'h0, 4'hF);
      acc("rd1024d", 0, 1, 32'd1024, 32'h0, 4'hF);
      acc("rd1026", 0, 1, 32'd1026, 32'h0, 4'hF);
      acc("wr1020", 1, 0, 32'd1020, 32'h00000055, 4'hF);
      acc("rd1276", 0, 1, 32'd1276, 32'h0, 4'hF);
      acc("rd1024e", 0, 1, 32'd1024, 32'h0, 4'hF);
      acc("rw1032", 1, 1, 32'd1032, 32'h12345678, 4'hF);
      acc("rd1032", 0, 1, 32'd1032, 32'h0, 4'hF);
      acc("wr1040", 1, 0, 32'd1040, 32'hAABBCCDD, 4'hF);
      acc("wr1040be", 1, 0, 32'd1040, 32'h11223344, 4'b0101);
      acc("rd1040", 0, 1, 32'd1040, 32'h0, 4'hF);
      acc("wr1040z", 1, 0, 32'd1040, 32'h99999999, 4'b0000);
      acc("rd1040b", 0, 1, 32'd1040, 32'h0, 4'hF);
      @(negedge clk);
      addr = 32'd1036; wdata = 32'h0BADF00D; mem_w_en = 1; mem_r_en = 0; byte_en = 4'hF;
      @(negedge clk);
      mem_w_en = 0;
      #2 rst = 1'b0;
      #2;
      chk("abort/ready3", {31'd0, ready3}, 32'd1);
      chk("abort/rdata3", rdata3, 32'd0);
      #1 rst = 1'b1;
      for (int i = 0; i < 64; i++) mdl[i] = '0;
      m_rd = '0;
      acc("rd1036", 0, 1, 32'd1036, 32'h0, 4'hF);
      acc("rd1028z", 0, 1, 32'd1028, 32'h0, 4'hF);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
